// File: rtl/au_pkg.sv
// Shared mode encoding and width helpers for the min/max/abs arithmetic unit.
package au_pkg;

  typedef enum logic [1:0] {
    AU_MAX     = 2'b00,
    AU_MIN     = 2'b01,
    AU_ABS     = 2'b10,
    AU_ABSDIFF = 2'b11
  } au_mode_e;

  // Largest positive two's-complement value representable in w bits (w <= 64).
  function automatic logic [63:0] au_signed_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/au_pipe_stage.sv
// Generic valid/ready register stage; accepts when empty or when its output is taken.
module au_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_advance;

  assign w_advance = !r_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Payload only loads on a real beat so a held or drained stage keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_advance) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/au_minmax_pipe.sv
// Two-stage signed max/min/abs/absdiff unit with valid/ready flow control.
// Optional clamping of modes 10/11 to the signed range when AU_SAT_EN is defined.
module au_minmax_pipe
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int P1_W = 3 * WIDTH + 3;
  localparam int P2_W = WIDTH + 1;

  logic [WIDTH:0]   w_diff;
  logic [P1_W-1:0]  w_s1_in;
  logic [P1_W-1:0]  w_s1_data;
  logic             w_s1_valid;
  logic             w_s2_ready;
  logic [1:0]       w_s1_sel;
  logic [WIDTH-1:0] w_s1_a;
  logic [WIDTH-1:0] w_s1_b;
  logic [WIDTH:0]   w_s1_diff;
  au_mode_e         w_mode;
  logic             w_diff_neg;
  logic [WIDTH-1:0] w_neg_a;
  logic [WIDTH-1:0] w_neg_diff_lo;
  logic [WIDTH-1:0] w_result;
  logic             w_sat;
  logic [P2_W-1:0]  w_s2_in;
  logic [P2_W-1:0]  w_s2_data;
  logic [CNT_W-1:0] r_done_cnt;

  // One extra bit of headroom keeps the subtraction exact for all operand pairs.
  assign w_diff  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign w_s1_in = {sel, a, b, w_diff};

  au_pipe_stage #(.W(P1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_s1_in),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_ready),
    .out_data  (w_s1_data)
  );

  assign w_s1_sel   = w_s1_data[3*WIDTH+2 : 3*WIDTH+1];
  assign w_s1_a     = w_s1_data[3*WIDTH   : 2*WIDTH+1];
  assign w_s1_b     = w_s1_data[2*WIDTH   : WIDTH+1];
  assign w_s1_diff  = w_s1_data[WIDTH:0];
  assign w_mode     = au_mode_e'(w_s1_sel);
  assign w_diff_neg = w_s1_diff[WIDTH];

  // Magnitudes only need the low WIDTH bits; negation modulo 2^WIDTH is exact there.
  assign w_neg_a       = '0 - w_s1_a;
  assign w_neg_diff_lo = '0 - w_s1_diff[WIDTH-1:0];

  always_comb begin
    w_result = '0;
    case (w_mode)
      AU_MAX:     w_result = w_diff_neg ? w_s1_b : w_s1_a;
      AU_MIN:     w_result = w_diff_neg ? w_s1_a : w_s1_b;
      AU_ABS:     w_result = w_s1_a[WIDTH-1] ? w_neg_a : w_s1_a;
      AU_ABSDIFF: w_result = w_diff_neg ? w_neg_diff_lo : w_s1_diff[WIDTH-1:0];
      default:    w_result = '0;
    endcase
  end

`ifdef AU_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(au_signed_max(WIDTH));

  // An unsigned magnitude exceeds the signed maximum exactly when its top bit is set.
  assign w_sat   = (w_mode == AU_ABS || w_mode == AU_ABSDIFF) && w_result[WIDTH-1];
  assign w_s2_in = {w_sat, (w_sat ? SMAX : w_result)};
`else
  assign w_sat   = 1'b0;
  assign w_s2_in = {w_sat, w_result};
`endif

  au_pipe_stage #(.W(P2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_ready),
    .in_data   (w_s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_data)
  );

  assign out_sat  = w_s2_data[WIDTH];
  assign out_data = w_s2_data[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign done_cnt = r_done_cnt;

endmodule
